// File: rtl/sprom_nport.sv
// sprom_nport: N-channel time-shared single-port memory.
// One block RAM is shared by NCH read channels and an external loader write port.
// Reads are scheduled either by fixed TDM slots (MODE 0) or by work-conserving
// round-robin (MODE 1). A loader write blocks read issue for that cycle, but it
// never blocks delivery of a read that is already in flight.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   ch_req      per-channel read request (level)
//   ch_addr     channel k read address in [k*AW +: AW]
//   ch_grant    combinational: channel k's read is issued this cycle (one-hot or zero)
//   ch_valid    registered one-cycle pulse: ch_rdata slice k has been updated
//   ch_rdata    channel k read data in [k*DW +: DW]; holds until k's next read
//   ext_addr    loader write address
//   ext_di      loader write data
//   ext_we      loader write enable; has priority over all reads
module sprom_nport #(
    parameter int unsigned AW            = 10,
    parameter int unsigned DW            = 8,
    parameter int unsigned NCH           = 4,
    parameter int unsigned MODE          = 0,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*AW-1:0] ch_addr,
    output logic [NCH-1:0]    ch_grant,
    output logic [NCH-1:0]    ch_valid,
    output logic [NCH*DW-1:0] ch_rdata,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DW-1:0]     ext_di,
    input  logic              ext_we
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [NCH-1:0] grant_c;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [PW-1:0] cand;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] rd_q;
    logic [PW-1:0] rd_ch;
    logic          rd_pend;

    // Scheduler: pick at most one channel; writes and reset suppress issue.
    always_comb begin
        grant_c = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        ptr_nxt = ptr;
        if (rst_n && !ext_we) begin
            if (MODE == 0) begin
                // Fixed slot: the slot advances whether or not its owner asked.
                if (ch_req[ptr]) begin
                    grant_c[ptr] = 1'b1;
                    gnt_idx      = ptr;
                    gnt_any      = 1'b1;
                end
                ptr_nxt = (32'(ptr) == NCH - 1) ? '0 : ptr + PW'(1);
            end else begin
                // Round-robin: first requester at or after ptr, idle channels skipped.
                for (int unsigned i = 0; i < NCH; i++) begin
                    cand = PW'((32'(ptr) + i) % NCH);
                    if (!gnt_any && ch_req[cand]) begin
                        grant_c[cand] = 1'b1;
                        gnt_idx       = cand;
                        gnt_any       = 1'b1;
                        ptr_nxt       = PW'((32'(cand) + 1) % NCH);
                    end
                end
            end
        end
    end

    assign ch_grant = grant_c;

    // Single shared RAM address: reads and writes never coincide.
    assign ram_addr = ext_we ? ext_addr : ch_addr[gnt_idx*AW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    // RAM write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (ext_we) begin
            mem[ram_addr] <= ext_di;
        end
    end

    // Stage 1: synchronous RAM read and tag of the owning channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            rd_ch   <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= gnt_any;
            if (gnt_any) begin
                rd_q  <= mem[ram_addr];
                rd_ch <= gnt_idx;
            end
        end
    end

    // Stage 2: steer read data to its channel and pulse that channel's valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_valid <= '0;
            ch_rdata <= '0;
        end else begin
            ch_valid <= '0;
            if (rd_pend) begin
                ch_valid[rd_ch]            <= 1'b1;
                ch_rdata[rd_ch*DW +: DW]   <= rd_q;
            end
        end
    end

endmodule
